// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: command encodings and FSM state type shared by the data memory slice.
package data_mem_resp_pkg;
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_WR   = 2'b01;
    localparam logic [1:0] MEM_RD   = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;
    typedef enum logic {INIT, READY} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 32-bit word storage, one synchronous write port and one asynchronous read port.
module dmem_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] w_idx,
    input  logic [31:0]           w_data,
    input  logic [DEPTH_LOG2-1:0] r_idx,
    output logic [31:0]           r_data
);
    logic [31:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk)
        if (we) mem[w_idx] <= w_data;
    assign r_data = mem[r_idx];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data memory with post-reset zero-fill walk, one-entry write buffer with
// read forwarding, and sticky/saturating fault reporting.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_ctrl_input,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err_sticky,
    output logic [7:0]  err_count,
    input  logic        err_clear
);
    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] cnt, cnt_nx, idx, wb_idx, arr_widx;
    logic [31:0]           wb_data, arr_wdata, arr_rdata;
    logic                  wb_valid, arr_we, bad_addr, fault, wr_ok;

    assign idx      = address[DEPTH_LOG2+1:2];
    assign bad_addr = (|address[31:DEPTH_LOG2+2]) || (|address[1:0]);

    // The array write port is shared: the zero-fill walk owns it in INIT, the write buffer in READY.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        arr_we    = 1'b0;
        arr_widx  = wb_idx;
        arr_wdata = wb_data;
        ready     = 1'b0;
        fault     = 1'b0;
        wr_ok     = 1'b0;
        read_data = '0;
        if (state == INIT) begin
            cnt_nx    = cnt + 1'b1;
            arr_we    = INIT_ZERO;
            arr_widx  = cnt;
            arr_wdata = '0;
            if (!INIT_ZERO || &cnt) state_nx = READY;
        end else begin
            ready  = 1'b1;
            arr_we = wb_valid;
            fault  = (mem_ctrl_input != MEM_IDLE) && (mem_ctrl_input == MEM_ILL || bad_addr);
            wr_ok  = (mem_ctrl_input == MEM_WR) && !bad_addr;
            if (mem_ctrl_input == MEM_RD && !bad_addr)
                read_data = (wb_valid && wb_idx == idx) ? wb_data : arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wb_valid <= 1'b0;
        else if (state == READY) wb_valid <= wr_ok;

    always_ff @(posedge clk)
        if (wr_ok) begin
            wb_idx  <= idx;
            wb_data <= w_data;
        end

    // A fault on the same edge as err_clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (fault) begin
            err_count  <= err_clear ? 8'd1 : err_count + {7'd0, err_count != 8'hFF};
            err_sticky <= 1'b1;
        end else if (err_clear) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk    (clk),
        .we     (arr_we),
        .w_idx  (arr_widx),
        .w_data (arr_wdata),
        .r_idx  (idx),
        .r_data (arr_rdata)
    );
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench driving a 16-word zero-filled instance and a 256-word no-init instance from shared inputs.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;
  localparam int D4 = 0, D8 = 1;
  localparam int K_RD = 0, K_CNT = 1, K_STK = 2, K_RDY = 3;
  typedef struct {
    int          cyc;
    int          sel;
    int          kind;
    string       name;
    logic [31:0] val;
  } ent_t;
  logic        clk, reset_n, err_clear;
  logic [1:0]  mem_ctrl_input;
  logic [31:0] address, w_data;
  logic [31:0] rd4, rd8;
  logic        rdy4, rdy8, stk4, stk8;
  logic [7:0]  cnt4, cnt8;
  ent_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  data_mem_resp #(.DEPTH_LOG2(4), .INIT_ZERO(1'b1)) dut4 (
    .clk(clk), .reset_n(reset_n), .mem_ctrl_input(mem_ctrl_input), .address(address),
    .w_data(w_data), .read_data(rd4), .ready(rdy4), .err_sticky(stk4),
    .err_count(cnt4), .err_clear(err_clear)
  );
  data_mem_resp #(.DEPTH_LOG2(8), .INIT_ZERO(1'b0)) dut8 (
    .clk(clk), .reset_n(reset_n), .mem_ctrl_input(mem_ctrl_input), .address(address),
    .w_data(w_data), .read_data(rd8), .ready(rdy8), .err_sticky(stk8),
    .err_count(cnt8), .err_clear(err_clear)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] actual(int sel, int kind);
    if (kind == K_RD)  return sel == D4 ? rd4 : rd8;
    if (kind == K_CNT) return {24'd0, sel == D4 ? cnt4 : cnt8};
    if (kind == K_STK) return {31'd0, sel == D4 ? stk4 : stk8};
    return {31'd0, sel == D4 ? rdy4 : rdy8};
  endfunction
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ent_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.sel, e.kind);
      n_tests++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s (dut%0d, cycle %0d): got %h, expected %h",
                 e.name, e.sel == D4 ? 4 : 8, e.cyc, a, e.val);
      end
    end
  end
  task automatic chk(int sel, int kind, string name, logic [31:0] val);
    ent_t e;
    e.cyc = cyc; e.sel = sel; e.kind = kind; e.name = name; e.val = val;
    sb.push_back(e);
  endtask
  task automatic chk2(int kind, string name, logic [31:0] val);
    chk(D4, kind, name, val);
    chk(D8, kind, name, val);
  endtask
  task automatic tick(logic [1:0] cmd, logic [31:0] addr, logic [31:0] wd, logic clr);
    @(posedge clk);
    #1;
    mem_ctrl_input = cmd;
    address        = addr;
    w_data         = wd;
    err_clear      = clr;
  endtask
  task automatic walk();
    reset_n        = 1'b1;
    mem_ctrl_input = MEM_ILL;
    chk(D4, K_RDY, "walk_ready_c0", 0);
    chk(D8, K_RDY, "noinit_ready_c0", 0);
    chk2(K_RD, "init_ill_rdata", 0);
    for (int k = 1; k < 16; k++) begin
      tick(MEM_RD, 32'h0, 32'h0, 1'b0);
      chk(D4, K_RDY, "walk_ready", 0);
      chk(D4, K_RD, "init_rdata", 0);
      if (k == 1) chk(D8, K_RDY, "noinit_ready_c1", 1);
    end
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk(D4, K_RDY, "walk_done", 1);
    chk2(K_CNT, "init_no_fault", 0);
  endtask
  initial begin
    reset_n = 1'b0;
    mem_ctrl_input = MEM_IDLE;
    address = '0;
    w_data = '0;
    err_clear = 1'b0;
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    tick(MEM_RD, 32'h0, 32'h0, 1'b0);
    chk2(K_RDY, "rst_ready", 0);
    chk2(K_RD, "rst_rdata", 0);
    chk2(K_CNT, "rst_count", 0);
    chk2(K_STK, "rst_sticky", 0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b1;
    repeat (4) tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk(D4, K_RDY, "midinit_d4_busy", 0);
    chk(D8, K_RDY, "midinit_d8_up", 1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b0;
    chk2(K_RDY, "midinit_rst_ready", 0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    walk();
    for (int k = 0; k < 16; k++) begin
      tick(MEM_RD, 32'(k * 4), 32'h0, 1'b0);
      chk(D4, K_RD, "zero_fill", 0);
    end
    tick(MEM_WR, 32'h10, 32'hDEADBEEF, 1'b0);
    tick(MEM_RD, 32'h10, 32'h0, 1'b0);
    chk2(K_RD, "fwd_read", 32'hDEADBEEF);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_RD, "idle_rdata", 0);
    tick(MEM_RD, 32'h10, 32'h0, 1'b0);
    chk2(K_RD, "array_read", 32'hDEADBEEF);
    tick(MEM_WR, 32'h20, 32'h1, 1'b0);
    tick(MEM_WR, 32'h20, 32'h2, 1'b0);
    tick(MEM_RD, 32'h20, 32'h0, 1'b0);
    chk2(K_RD, "b2b_fwd", 32'h2);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    tick(MEM_RD, 32'h20, 32'h0, 1'b0);
    chk2(K_RD, "b2b_array", 32'h2);
    tick(MEM_WR, 32'h0, 32'h12345678, 1'b0);
    tick(MEM_WR, 32'h8, 32'h11112222, 1'b0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "no_fault_yet", 0);
    chk2(K_STK, "no_sticky_yet", 0);
    tick(MEM_RD, 32'h13, 32'h0, 1'b0);
    chk2(K_RD, "misaligned_rd", 0);
    tick(MEM_WR, 32'h400, 32'h55, 1'b0);
    tick(MEM_ILL, 32'h10, 32'h0, 1'b0);
    chk2(K_RD, "illegal_rdata", 0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "three_faults", 3);
    chk2(K_STK, "sticky_set", 1);
    tick(MEM_RD, 32'h0, 32'h0, 1'b0);
    chk2(K_RD, "oor_write_dropped", 32'h12345678);
    tick(MEM_WR, 32'h12, 32'hBAD, 1'b0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    tick(MEM_RD, 32'h10, 32'h0, 1'b0);
    chk2(K_RD, "misaligned_wr_dropped", 32'hDEADBEEF);
    chk2(K_CNT, "four_faults", 4);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "clear_count", 0);
    chk2(K_STK, "clear_sticky", 0);
    for (int k = 0; k < 300; k++) begin
      tick(MEM_ILL, 32'h0, 32'h0, 1'b0);
      if (k == 10) chk2(K_CNT, "count_10", 10);
    end
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "saturate_255", 255);
    tick(MEM_ILL, 32'h0, 32'h0, 1'b1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "clear_fault_count", 1);
    chk2(K_STK, "clear_fault_sticky", 1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    chk2(K_CNT, "reclear_count", 0);
    tick(MEM_ILL, 32'h0, 32'h0, 1'b0);
    tick(MEM_WR, 32'h8, 32'hCAFEF00D, 1'b0);
    chk2(K_CNT, "pre_rst_count", 1);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b0;
    chk2(K_RDY, "wb_rst_ready", 0);
    chk2(K_CNT, "wb_rst_count", 0);
    chk2(K_STK, "wb_rst_sticky", 0);
    tick(MEM_RD, 32'h8, 32'h0, 1'b0);
    chk2(K_RD, "rst_read_zero", 0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    walk();
    tick(MEM_RD, 32'h8, 32'h0, 1'b0);
    chk(D4, K_RD, "rewalk_zero", 0);
    chk(D8, K_RD, "wb_lost_on_reset", 32'h11112222);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    tick(MEM_IDLE, 32'h0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (rdy4 !== 1'b1 || rdy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL final_ready: got %b/%b, expected 1/1", rdy4, rdy8);
    end
    n_tests++;
    if (cnt4 !== 8'd0 || cnt8 !== 8'd0) begin
      n_fail++;
      $display("FAIL final_count: got %h/%h, expected 0/0", cnt4, cnt8);
    end
    n_tests++;
    if (stk4 !== 1'b0 || stk8 !== 1'b0) begin
      n_fail++;
      $display("FAIL final_sticky: got %b/%b, expected 0/0", stk4, stk8);
    end
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h", e.name, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-address width; the array holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1; 1 enables the post-reset zero-fill walk, 0 skips it.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_ctrl_input  input  2  access command: bit1 = read, bit0 = write; 2'b00 idle, 2'b11 illegal.
REQ-006 address  input  32  byte address from the pipeline memory stage.
REQ-007 w_data  input  32  store data.
REQ-008 read_data  output  32  load data, combinational, valid in the same cycle as the read command.
REQ-009 ready  output  1  high when the init walk is done and accesses are served.
REQ-010 err_sticky  output  1  set by any faulting access, held until cleared.
REQ-011 err_count  output  8  saturating count of faulting accesses.
REQ-012 err_clear  input  1  synchronous clear of err_sticky and err_count.

Function
REQ-013 Word index = address[DEPTH_LOG2+1:2]; out-of-range = any bit of address[31:DEPTH_LOG2+2] set; misaligned = address[1:0] != 0.
REQ-014 A fault is a read or write command that is misaligned or out-of-range, or a 2'b11 command; a faulting read returns 0; a faulting write is dropped.
REQ-015 The FSM has two states, INIT and READY; reset enters INIT with the walk counter at 0.
REQ-016 In INIT with INIT_ZERO=1: write 0 to word [counter] each cycle; after word DEPTH-1 is written, go to READY (ready=1 on the next cycle; DEPTH cycles total).
REQ-017 In INIT with INIT_ZERO=0: go to READY on the first edge after reset release.
REQ-018 In INIT: commands are ignored, no faults are counted, read_data=0, ready=0.
REQ-019 Writes pass through a one-entry write buffer (wb_valid, wb_idx, wb_data).
REQ-020 Write buffer, every edge in READY:
  - if wb_valid, commit wb_data to array[wb_idx];
  - then load the buffer with a non-faulting write command if present, else clear wb_valid.
REQ-021 Read: if wb_valid and wb_idx equals the read index, read_data = wb_data (forwarding); otherwise read_data = array[index].
REQ-022 Back-to-back writes to the same index: a later read returns the newest data.
REQ-023 Non-read or idle cycles: read_data = 0.
REQ-024 A fault edge increments err_count, saturating at 255, and sets err_sticky.
REQ-025 err_clear alone sets err_count=0 and err_sticky=0.
REQ-026 err_clear and a fault on the same edge: err_count=1 and err_sticky=1 (the fault wins).

Reset
REQ-027 Asserting reset_n low, including during INIT or with a buffered write:
  - outputs: ready=0, err_sticky=0, err_count=0, read_data=0;
  - state: wb_valid=0 (the pending write is lost); FSM to INIT with counter=0.
REQ-028 Array contents are not reset; clearing them relies on the INIT walk only.

Structure
REQ-029 A shared package holds:
  - the command encodings MEM_IDLE=2'b00, MEM_WR=2'b01, MEM_RD=2'b10, MEM_ILL=2'b11;
  - the FSM state typedef {INIT, READY}.
REQ-030 The storage array is sub-module dmem_array: one synchronous write port and one asynchronous read port; the buffer, FSM and error logic stay in the top module.

Verification
REQ-031 Reset release, INIT_ZERO=1, DEPTH_LOG2=4 -> ready=0 for exactly 16 cycles, then 1; reads of every word return 0.
REQ-032 Write 0xDEADBEEF to 0x10, then read 0x10 on the next cycle -> 0xDEADBEEF via forwarding; read again 2 cycles later -> 0xDEADBEEF from the array.
REQ-033 Writes to 0x20 of 0x1, then 0x2 on consecutive cycles, then read 0x20 -> 0x2.
REQ-034 Read at 0x13, write at 0x400 (DEPTH_LOG2=8), then a 2'b11 command -> read_data=0, array unchanged, err_count=3, err_sticky=1.
REQ-035 300 consecutive faults -> err_count=255; err_clear with a simultaneous fault -> err_count=1, err_sticky=1.
REQ-036 Reset asserted mid-INIT and with wb_valid=1 -> ready drops immediately; the buffered write is never committed; a full INIT walk restarts.
